frame_step_sched: RTL and testbench

FRAME_STEP_SCHED -- requirements
Module: frame_step_sched

---
 rtl/game_pkg.sv | 16 +
 rtl/phase_watchdog.sv | 25 ++
 rtl/frame_step_sched.sv | 134 +++++++++++++
 tb/tb_frame_step_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game phase constants and frame scheduler state type
package game_pkg;

  localparam logic [1:0] START = 2'b00;
  localparam logic [1:0] GAME  = 2'b01;
  localparam logic [1:0] END   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    IN_RUN,
    LOGIC_RUN,
    RENDER_RUN
  } sched_state_t;

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-phase busy counter that expires after TIMEOUT cycles
module phase_watchdog #(
  parameter logic [19:0] TIMEOUT = 20'd833333
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 20'd0;
    end else if (run) begin
      cnt <= cnt + 20'd1;
    end
  end

  // Counter reads k-1 during the k-th cycle of a phase, so this fires on cycle TIMEOUT.
  assign expire = run && (cnt == TIMEOUT - 20'd1);

endmodule

// File: rtl/frame_step_sched.sv
// rtl/frame_step_sched.sv - sequences input, logic and render phases once per frame tick
module frame_step_sched
  import game_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = 20'd833333,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_req,
  input  logic [1:0]       game_state,
  input  logic             in_done,
  input  logic             logic_done,
  input  logic             render_done,
  output logic             tick_ack,
  output logic             in_start,
  output logic             logic_start,
  output logic             render_start,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             timeout_err
);

  sched_state_t state, state_next;
  logic         tick_q;
  logic         tick_rise;
  logic         expire;
  logic         wd_run;
  logic         wd_clear;
  logic         frame_inc;
  logic         timeout_hit;

  phase_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .run   (wd_run),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    tick_ack     = 1'b0;
    in_start     = 1'b0;
    logic_start  = 1'b0;
    render_start = 1'b0;
    frame_inc    = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (tick_req) state_next = ACK;
      end
      ACK: begin
        tick_ack   = 1'b1;
        in_start   = 1'b1;
        state_next = IN_RUN;
      end
      IN_RUN: begin
        // game_state matters only here; a done pulse beats a simultaneous expiry.
        if (in_done) begin
          if (game_state == GAME) begin
            state_next  = LOGIC_RUN;
            logic_start = 1'b1;
          end else begin
            state_next   = RENDER_RUN;
            render_start = 1'b1;
          end
        end else if (expire) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      LOGIC_RUN: begin
        if (logic_done) begin
          state_next   = RENDER_RUN;
          render_start = 1'b1;
        end else if (expire) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      RENDER_RUN: begin
        if (render_done) begin
          state_next = IDLE;
          frame_inc  = 1'b1;
        end else if (expire) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A frame abandoned by reset must not leak a pulse in the reset cycle.
    if (rst) begin
      tick_ack     = 1'b0;
      in_start     = 1'b0;
      logic_start  = 1'b0;
      render_start = 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign wd_run    = (state == IN_RUN) || (state == LOGIC_RUN) || (state == RENDER_RUN);
  assign wd_clear  = (state_next != state);
  assign tick_rise = tick_req && !tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tick_q <= tick_req;
      if (frame_inc) frame_cnt <= frame_cnt + CNT_W'(1);
      if (timeout_hit) timeout_err <= 1'b1;
      if (tick_rise && busy && (state != ACK) && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_step_sched.sv
// tb/tb_frame_step_sched.sv - directed and randomized bench for frame_step_sched
module tb_frame_step_sched;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int FMAX = 1 << CW;
  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] E = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_req = 1'b0;
  logic [1:0]    game_state = 2'b00;
  logic          in_done = 1'b0;
  logic          logic_done = 1'b0;
  logic          render_done = 1'b0;
  logic          tick_ack, in_start, logic_start, render_start, busy, timeout_err;
  logic [CW-1:0] frame_cnt, overrun_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_step_sched #(
    .TIMEOUT(20'd16),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_req    (tick_req),
    .game_state  (game_state),
    .in_done     (in_done),
    .logic_done  (logic_done),
    .render_done (render_done),
    .tick_ack    (tick_ack),
    .in_start    (in_start),
    .logic_start (logic_start),
    .render_start(render_start),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 ack, 2 input, 3 logic, 4 render; age = cycles spent in a run phase.
  int m_phase = 0, m_age = 0, m_frames = 0, m_over = 0;
  bit m_terr = 0, m_prev = 0, m_valid = 0;

  always @(negedge clk) begin
    bit dn;
    if (m_valid) begin
      chk1("m_busy", busy, m_phase != 0);
      chk1("m_tick_ack", tick_ack, !rst && m_phase == 1);
      chk1("m_in_start", in_start, !rst && m_phase == 1);
      chk1("m_logic_start", logic_start, !rst && m_phase == 2 && in_done && game_state == G);
      chk1("m_render_start", render_start,
           !rst && ((m_phase == 2 && in_done && game_state != G) || (m_phase == 3 && logic_done)));
      chkn("m_frame_cnt", frame_cnt, CW'(m_frames));
      chkn("m_overrun_cnt", overrun_cnt, CW'(m_over));
      chk1("m_timeout_err", timeout_err, m_terr);
    end
    if (rst) begin
      m_phase = 0; m_age = 0; m_frames = 0; m_over = 0;
      m_terr = 0; m_prev = 0; m_valid = 1;
    end else if (m_valid) begin
      if (tick_req && !m_prev && m_phase >= 2 && m_over < FMAX - 1) m_over++;
      m_prev = tick_req;
      case (m_phase)
        0: if (tick_req) m_phase = 1;
        1: begin m_phase = 2; m_age = 0; end
        default: begin
          m_age++;
          dn = (m_phase == 2) ? in_done : (m_phase == 3) ? logic_done : render_done;
          if (dn) begin
            if (m_phase == 2) m_phase = (game_state == G) ? 3 : 4;
            else if (m_phase == 3) m_phase = 4;
            else begin m_phase = 0; m_frames = (m_frames + 1) % FMAX; end
            m_age = 0;
          end else if (m_age == TO) begin
            m_phase = 0;
            m_terr = 1;
          end
        end
      endcase
    end
  end

  task automatic cyc(input int r, input int t, input logic [1:0] g, input int i, input int l, input int d);
    @(posedge clk);
    #1;
    rst = (r != 0); tick_req = (t != 0); game_state = g;
    in_done = (i != 0); logic_done = (l != 0); render_done = (d != 0);
    #1;
  endtask

  initial begin
    int dens;
    cyc(1, 0, G, 0, 0, 0);
    cyc(1, 0, G, 0, 0, 0);

    // GAME frame with one-cycle done responses
    cyc(0, 1, G, 0, 0, 0);
    chk1("rst_busy", busy, 1'b0); chkn("rst_frame", frame_cnt, CW'(0));
    chkn("rst_overrun", overrun_cnt, CW'(0)); chk1("rst_terr", timeout_err, 1'b0);
    chk1("rst_ack", tick_ack, 1'b0);
    cyc(0, 1, G, 0, 0, 0);
    chk1("g_ack", tick_ack, 1'b1); chk1("g_in_start", in_start, 1'b1); chk1("g_busy", busy, 1'b1);
    cyc(0, 0, G, 1, 0, 0);
    chk1("g_logic_start", logic_start, 1'b1); chk1("g_no_render_early", render_start, 1'b0);
    cyc(0, 0, G, 0, 1, 0);
    chk1("g_render_start", render_start, 1'b1); chk1("g_logic_once", logic_start, 1'b0);
    cyc(0, 0, G, 0, 0, 1);
    chkn("g_frame_before", frame_cnt, CW'(0));
    cyc(0, 0, G, 0, 0, 0);
    chkn("g_frame_after", frame_cnt, CW'(1)); chk1("g_idle", busy, 1'b0);
    repeat (3) begin cyc(0, 0, G, 0, 0, 0); chk1("g_no_reack", tick_ack, 1'b0); end

    // START frame skips logic; stray logic_done in render ignored
    cyc(0, 1, S, 0, 0, 0);
    cyc(0, 1, S, 0, 0, 0); chk1("s_ack", tick_ack, 1'b1);
    cyc(0, 0, S, 1, 0, 0);
    chk1("s_render_start", render_start, 1'b1); chk1("s_no_logic", logic_start, 1'b0);
    cyc(0, 0, S, 0, 1, 0); chk1("s_stray_logic", render_start, 1'b0);
    cyc(0, 0, S, 0, 0, 1);
    cyc(0, 0, S, 0, 0, 0); chkn("s_frame", frame_cnt, CW'(2));

    // logic phase timeout, then done arriving on the expiry cycle wins
    cyc(0, 1, G, 0, 0, 0);
    cyc(0, 1, G, 0, 0, 0);
    cyc(0, 0, G, 1, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 0, G, 0, 0, 0);
      chk1("to_busy", busy, 1'b1);
    end
    cyc(0, 0, G, 0, 0, 0);
    chk1("to_idle", busy, 1'b0); chk1("to_terr", timeout_err, 1'b1); chkn("to_frame", frame_cnt, CW'(2));
    cyc(0, 1, G, 0, 0, 0);
    cyc(0, 1, G, 0, 0, 0); chk1("to_next_ack", tick_ack, 1'b1);
    cyc(0, 0, G, 1, 0, 0);
    for (int k = 1; k < TO; k++) cyc(0, 0, G, 0, 0, 0);
    cyc(0, 0, G, 0, 1, 0); chk1("to_done_wins", render_start, 1'b1);
    cyc(0, 0, G, 0, 0, 1); chk1("to_render_busy", busy, 1'b1);
    cyc(0, 0, G, 0, 0, 0); chkn("to_frame2", frame_cnt, CW'(3)); chk1("to_terr_sticky", timeout_err, 1'b1);

    // two tick rising edges during one render phase
    cyc(0, 1, E, 0, 0, 0);
    cyc(0, 1, E, 0, 0, 0);
    cyc(0, 0, E, 1, 0, 0);
    cyc(0, 1, E, 0, 0, 0);
    cyc(0, 0, E, 0, 0, 0);
    cyc(0, 1, E, 0, 0, 0);
    cyc(0, 1, E, 0, 0, 1); chkn("ov_two", overrun_cnt, CW'(2));
    cyc(0, 1, E, 0, 0, 0); chkn("ov_frame", frame_cnt, CW'(4));
    cyc(0, 1, E, 0, 0, 0); chk1("ov_pending_ack", tick_ack, 1'b1);
    cyc(0, 0, E, 1, 0, 0);
    cyc(0, 0, E, 0, 0, 1);
    cyc(0, 0, E, 0, 0, 0); chkn("ov_frame2", frame_cnt, CW'(5));

    // reset in the middle of the logic phase
    cyc(0, 1, G, 0, 0, 0);
    cyc(0, 1, G, 0, 0, 0);
    cyc(0, 0, G, 1, 0, 0);
    cyc(1, 0, G, 0, 1, 0);
    chk1("mr_no_render", render_start, 1'b0); chk1("mr_no_logic", logic_start, 1'b0);
    cyc(0, 0, G, 0, 1, 0);
    chk1("mr_busy", busy, 1'b0); chkn("mr_frame", frame_cnt, CW'(0));
    chkn("mr_overrun", overrun_cnt, CW'(0)); chk1("mr_terr", timeout_err, 1'b0);
    chk1("mr_stray", render_start, 1'b0);
    cyc(0, 0, G, 0, 0, 0); chk1("mr_idle", busy, 1'b0);

    // frame counter wrap over 16 short frames
    for (int f = 0; f < FMAX; f++) begin
      cyc(0, 1, S, 0, 0, 0);
      if (f == FMAX - 1) chkn("wrap_pre", frame_cnt, CW'(FMAX - 1));
      cyc(0, 1, S, 0, 0, 0);
      cyc(0, 0, S, 1, 0, 0);
      cyc(0, 0, S, 0, 0, 1);
    end
    cyc(0, 0, S, 0, 0, 0); chkn("wrap_zero", frame_cnt, CW'(0));

    // overrun saturation: 18 rising edges across three frames
    for (int f = 0; f < 3; f++) begin
      cyc(0, 1, S, 0, 0, 0);
      cyc(0, 1, S, 0, 0, 0);
      cyc(0, 0, S, 1, 0, 0);
      for (int j = 0; j < 12; j++) cyc(0, j % 2, S, 0, 0, 0);
      cyc(0, 0, S, 0, 0, 1);
    end
    cyc(0, 0, S, 0, 0, 0);
    chkn("ov_saturate", overrun_cnt, CW'(FMAX - 1)); chkn("ov_sat_frames", frame_cnt, CW'(3));

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(1, 3);
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) tick_req = ~tick_req;
      if ($urandom_range(0, 15) == 0) game_state = 2'($urandom_range(0, 3));
      in_done     = ($urandom_range(0, dens * dens * 3) == 0);
      logic_done  = ($urandom_range(0, dens * dens * 3) == 0);
      render_done = ($urandom_range(0, dens * dens * 3) == 0);
    end
    cyc(0, 0, S, 0, 0, 0);
    cyc(0, 0, S, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
